// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: EXE_CMD encodings, multiplier state type and datapath width shared by ID and EX
package exe_stage_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [3:0] {
    CMD_ADD = 4'b0000,
    CMD_SUB = 4'b0010,
    CMD_AND = 4'b0100,
    CMD_OR  = 4'b0101,
    CMD_NOR = 4'b0110,
    CMD_XOR = 4'b0111,
    CMD_SLL = 4'b1000,
    CMD_SRA = 4'b1001,
    CMD_SRL = 4'b1010,
    CMD_MUL = 4'b1100
  } exe_cmd_e;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EX operand bus in, EX/MEM result bus and stall out
interface exe_stage_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] PC_in, Val1, Val2, Reg2_in;
  logic [4:0] Dest_in;
  logic [3:0] EXE_CMD;
  logic Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in;
  logic [DATA_W-1:0] ALU_result, Br_addr, Reg2;
  logic [4:0] Dest;
  logic Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall;
  modport stage (
    input  PC_in, Val1, Val2, Reg2_in, Dest_in, EXE_CMD,
           Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
    output ALU_result, Br_addr, Reg2, Dest, Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall
  );
  modport pipe (
    output PC_in, Val1, Val2, Reg2_in, Dest_in, EXE_CMD,
           Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in,
    input  ALU_result, Br_addr, Reg2, Dest, Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, stall
  );
endinterface

// File: rtl/exe_multiplier.sv
// exe_multiplier: iterative shift-add multiplier, one multiplier bit per cycle, LSB first
module exe_multiplier import exe_stage_pkg::*; #(parameter int DATA_W = exe_stage_pkg::DATA_W) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic busy,
  output logic done,
  output logic [DATA_W-1:0] product
);
  localparam logic [5:0] LAST = 6'(DATA_W - 1);
  mul_state_e state;
  logic [5:0] cnt;
  logic [DATA_W-1:0] mcand, mplier;
  // low word of a two's-complement product is sign-agnostic, so no sign handling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      product <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mcand <= a;
          mplier <= b;
          product <= '0;
          cnt <= '0;
          state <= S_BUSY;
        end
        S_BUSY: begin
          product <= product + (mplier[0] ? mcand : '0);
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 6'd1;
          state <= cnt == LAST ? S_DONE : S_BUSY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  assign busy = state == S_BUSY;
  assign done = state == S_DONE;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: single-cycle ALU, branch target adder and stalling multi-cycle multiplier
module exe_stage import exe_stage_pkg::*; #(parameter int DATA_W = exe_stage_pkg::DATA_W) (
  input logic clk,
  input logic rst,
  input logic flush,
  exe_stage_if.stage bus
);
  logic mul_cmd, busy, done, stall, bubble;
  logic [DATA_W-1:0] product;
  logic [4:0] sh;
  assign mul_cmd = bus.EXE_CMD == CMD_MUL;
  assign sh = bus.Val2[4:0];
  exe_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(mul_cmd),
    .flush(flush),
    .a(bus.Val1),
    .b(bus.Val2),
    .busy(busy),
    .done(done),
    .product(product)
  );
  // the DONE cycle releases the stall even though EXE_CMD still reads MUL
  assign stall = !flush && (busy || (mul_cmd && !done));
  assign bubble = stall || flush;
  assign bus.stall = stall;
  assign bus.Br_taken = !bubble && bus.Br_taken_in;
  assign bus.MEM_R_EN = !bubble && bus.MEM_R_EN_in;
  assign bus.MEM_W_EN = !bubble && bus.MEM_W_EN_in;
  assign bus.WB_EN = !bubble && bus.WB_EN_in;
  assign bus.Dest = bus.Dest_in;
  assign bus.Reg2 = bus.Reg2_in;
  assign bus.Br_addr = bus.PC_in + (bus.Val2 << 2);
  always_comb begin
    case (bus.EXE_CMD)
      CMD_ADD: bus.ALU_result = bus.Val1 + bus.Val2;
      CMD_SUB: bus.ALU_result = bus.Val1 - bus.Val2;
      CMD_AND: bus.ALU_result = bus.Val1 & bus.Val2;
      CMD_OR:  bus.ALU_result = bus.Val1 | bus.Val2;
      CMD_NOR: bus.ALU_result = ~(bus.Val1 | bus.Val2);
      CMD_XOR: bus.ALU_result = bus.Val1 ^ bus.Val2;
      CMD_SLL: bus.ALU_result = bus.Val1 << sh;
      CMD_SRA: bus.ALU_result = $signed(bus.Val1) >>> sh;
      CMD_SRL: bus.ALU_result = bus.Val1 >> sh;
      CMD_MUL: bus.ALU_result = done ? product : '0;
      default: bus.ALU_result = '0;
    endcase
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: random and directed checks of exe_stage against a behavioural model
module tb_exe_stage;
  logic clk = 0, rst = 1, flush = 0;
  int total = 0, bad = 0, cyc = 0;
  exe_stage_if #(32) bus();
  exe_stage #(.DATA_W(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int unsigned s;
    longint unsigned w;
    s = y[4:0];
    w = x;
    case (c)
      4'd0: return x + y;
      4'd2: return x - y;
      4'd4: return x & y;
      4'd5: return x | y;
      4'd6: return ~(x | y);
      4'd7: return x ^ y;
      4'd8: return 32'(w * (64'd1 << s));
      4'd9: return x[31] ? ~((~x) >> s) : x >> s;
      4'd10: return 32'(w / (64'd1 << s));
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    bus.EXE_CMD = c;
    bus.Val1 = x;
    bus.Val2 = y;
    bus.PC_in = $urandom;
    bus.Reg2_in = $urandom;
    bus.Dest_in = 5'($urandom);
    {bus.Br_taken_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in} = 4'($urandom);
  endtask

  task automatic check_comb(input string tag);
    chk({tag, ".alu"}, bus.ALU_result, ref_alu(bus.EXE_CMD, bus.Val1, bus.Val2));
    chk({tag, ".br"}, bus.Br_addr, bus.PC_in + bus.Val2 * 4);
    chk({tag, ".pass"}, {bus.Dest, bus.Reg2[26:0]}, {bus.Dest_in, bus.Reg2_in[26:0]});
    chk({tag, ".reg2hi"}, 32'(bus.Reg2[31:27]), 32'(bus.Reg2_in[31:27]));
    chk({tag, ".ctl"}, {bus.stall, bus.Br_taken, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN},
        {1'b0, bus.Br_taken_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in});
  endtask

  task automatic chk_bubble(input string tag, input logic st);
    chk(tag, {bus.stall, bus.Br_taken, bus.MEM_R_EN, bus.MEM_W_EN, bus.WB_EN}, {st, 4'b0});
  endtask

  task automatic do_mul(input logic [31:0] x, input logic [31:0] y, output int t_done);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    tick;
    drive(4'hC, x, y);
    {bus.Br_taken_in, bus.MEM_R_EN_in, bus.MEM_W_EN_in, bus.WB_EN_in} = 4'hF;
    for (int i = 0; i < 33; i++) begin
      #2;
      chk_bubble("mul.stall", 1'b1);
      tick;
    end
    #2;
    chk("mul.result", bus.ALU_result, 32'(p));
    chk("mul.release", {bus.stall, bus.WB_EN, bus.MEM_R_EN}, 3'b011);
    t_done = cyc;
  endtask

  initial begin
    int t1, t2;
    logic [3:0] codes [15];
    logic [31:0] x, y;
    codes = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1, 4'd3, 4'd11, 4'd13, 4'd14, 4'd15};
    drive(4'd0, 32'd3, 32'd4);
    #2;
    check_comb("rst.add");
    bus.EXE_CMD = 4'hC;
    bus.WB_EN_in = 1;
    #1;
    chk_bubble("rst.mul", 1'b1);
    bus.EXE_CMD = 4'd5;
    #1;
    check_comb("rst.or");
    tick;
    tick;
    rst = 0;
    drive(4'd0, 32'h7FFF_FFFF, 32'd1);
    #2;
    check_comb("add.ovf");
    chk("add.val", bus.ALU_result, 32'h8000_0000);
    tick;
    drive(4'd2, 32'd0, 32'd1);
    #2;
    chk("sub.val", bus.ALU_result, 32'hFFFF_FFFF);
    chk("sub.stall", bus.stall, 0);
    tick;
    drive(4'd9, 32'h8000_0000, 32'd4);
    #2;
    chk("sra.val", bus.ALU_result, 32'hF800_0000);
    bus.EXE_CMD = 4'd10;
    #1;
    chk("srl.val", bus.ALU_result, 32'h0800_0000);
    bus.PC_in = 32'h100;
    bus.Val2 = 32'd3;
    #1;
    chk("br.val", bus.Br_addr, 32'h10C);
    for (int i = 0; i < 60; i++) begin
      tick;
      drive(codes[$urandom_range(0, 14)], $urandom, $urandom);
      #2;
      check_comb("rand");
    end
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, t1);
    do_mul(32'd6, 32'd7, t1);
    do_mul(32'd3, 32'd5, t2);
    chk("b2b.gap", t2 - t1, 34);
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, t1);
    // flush on BUSY cycle 10
    tick;
    drive(4'hC, 32'd9, 32'd9);
    bus.WB_EN_in = 1;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk_bubble("fl.stall", 1'b1);
      tick;
    end
    flush = 1;
    #2;
    chk_bubble("fl.kill", 1'b0);
    tick;
    flush = 0;
    drive(4'd0, $urandom, $urandom);
    #2;
    check_comb("fl.add");
    do_mul(32'hFFFF_FFF9, 32'd11, t1);
    // command and operands wander during BUSY
    x = $urandom;
    y = $urandom;
    tick;
    drive(4'hC, x, y);
    for (int i = 0; i < 33; i++) begin
      if (i >= 3 && i <= 20) begin
        bus.EXE_CMD = codes[$urandom_range(0, 14)];
        bus.Val1 = $urandom;
        bus.Val2 = $urandom;
      end
      if (i == 21) begin
        bus.EXE_CMD = 4'hC;
        bus.Val1 = $urandom;
        bus.Val2 = $urandom;
      end
      #2;
      chk("chg.stall", bus.stall, 1);
      tick;
    end
    #2;
    chk("chg.result", bus.ALU_result, x * y);
    chk("chg.stall_end", bus.stall, 0);
    // reset on BUSY cycle 5
    tick;
    drive(4'hC, 32'd12, 32'd13);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("rm.stall", bus.stall, 1);
      tick;
    end
    rst = 1;
    drive(4'd5, $urandom, $urandom);
    #2;
    check_comb("rm.or");
    tick;
    rst = 0;
    for (int i = 0; i < 36; i++) begin
      #2;
      check_comb("rm.after");
      tick;
    end
    do_mul(32'd100, 32'hFFFF_FFFF, t1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width; the multiply iteration count equals DATA_W.
REQ-002 SHALL have port clk, input, 1: clock, rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1: abort any in-flight multiply.
REQ-005 SHALL have ports PC_in, Val1, Val2, Reg2_in, input, DATA_W each: ID/EX operands and store data.
REQ-006 SHALL have ports Dest_in (input, 5) and EXE_CMD (input, 4).
REQ-007 SHALL have ports Br_taken_in, MEM_R_EN_in, MEM_W_EN_in, WB_EN_in, input, 1 each.
REQ-008 SHALL have ports ALU_result and Br_addr, output, DATA_W each.
REQ-009 SHALL have ports Dest (output, 5) and Reg2 (output, DATA_W): pass-through to EX/MEM.
REQ-010 SHALL have ports Br_taken, MEM_R_EN, MEM_W_EN, WB_EN, output, 1 each.
REQ-011 SHALL have port stall, output, 1: hold PC, IF/ID and ID/EX.

Function
REQ-012 SHALL decode EXE_CMD as ADD=0000, SUB=0010, AND=0100, OR=0101, NOR=0110, XOR=0111, SLL=1000, SRA=1001, SRL=1010, MUL=1100; any other code yields ALU_result=0.
REQ-013 SHALL compute every non-MUL result combinationally from Val1/Val2 in the same cycle: wrap-around modulo 2^DATA_W, no overflow flag, shift amount Val2[4:0].
REQ-014 SHALL drive Br_addr = PC_in + (Val2 << 2), modulo 2^DATA_W, for every command.
REQ-015 SHALL pass Dest_in and Reg2_in to Dest and Reg2 unchanged, combinationally.
REQ-016 SHALL run a multiply FSM with states IDLE, BUSY, DONE and a 6-bit iteration counter.
REQ-017 IDLE with EXE_CMD=MUL: stall=1; at the clock edge latch Val1/Val2, clear the product and counter, and go to BUSY.
REQ-018 BUSY: stall=1; perform one shift-add step per cycle (LSB-first multiplier); after DATA_W steps go to DONE.
REQ-019 DONE: stall=0; ALU_result = low DATA_W bits of the product; next edge go to IDLE.
REQ-020 SHALL hold stall high for exactly DATA_W+1 consecutive cycles per MUL; the result appears in the following cycle.
REQ-021 The product low word SHALL be correct for both signed and unsigned operands.
REQ-022 While stall=1, SHALL force Br_taken, MEM_R_EN, MEM_W_EN and WB_EN to 0 (bubble downstream); otherwise pass the *_in values through.
REQ-023 With flush=1 in any state: go to IDLE at the next edge, and force stall, Br_taken, MEM_R_EN, MEM_W_EN and WB_EN to 0 in that cycle.
REQ-024 Back-to-back MULs: the DONE→IDLE transition precedes detection of the next MUL, so each MUL costs DATA_W+2 cycles.
REQ-025 A change of EXE_CMD during BUSY (illegal, since inputs are held by stall) SHALL NOT affect the FSM or the latched operands.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE and clear counter, product and operand registers.
REQ-027 During and after reset, outputs SHALL be the combinational functions of the inputs with state IDLE; in particular stall=1 only if EXE_CMD=MUL.
REQ-028 Reset asserted mid-multiply SHALL discard the operation; no partial result is ever presented.

Structure
REQ-029 A shared package SHALL hold the EXE_CMD encodings, the FSM state type and DATA_W; the ID stage imports the same package.
REQ-030 The multiplier FSM and datapath SHALL be a sub-module named exe_multiplier (ports: start, flush, operands, busy, done, product).

Verification
REQ-031 ADD 0x7FFFFFFF+1 -> ALU_result=0x80000000 in the same cycle; SUB 0-1 -> 0xFFFFFFFF; stall=0.
REQ-032 SRA Val1=0x80000000, Val2=4 -> 0xF8000000; SRL same operands -> 0x08000000; PC_in=0x100, Val2=3 -> Br_addr=0x10C.
REQ-033 MUL 0xFFFFFFFF×0xFFFFFFFF with WB_EN_in=1 -> stall high 33 cycles, WB_EN=0 throughout; 34th cycle ALU_result=0x00000001, WB_EN=1.
REQ-034 Two back-to-back MULs 6×7 then 3×5 -> results 42 and 15 exactly 34 cycles apart.
REQ-035 MUL with flush pulsed on BUSY cycle 10 -> stall=0 next cycle, state IDLE; a subsequent ADD completes normally.
REQ-036 rst asserted on BUSY cycle 5 with EXE_CMD switched to OR -> stall=0 immediately, no DONE cycle, OR result correct.
